// File: rtl/trap_ctrl.sv
// Trap entry sequencer: picks one exception or interrupt by fixed priority,
// flushes the pipeline, strobes the CSR file and stalls until it acknowledges.
module trap_ctrl #(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 2,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            EXC_VALID,
  input  logic [4:0]      EXC_CODE,
  input  logic [XLEN-1:0] EXC_PC,
  input  logic            RETIRE_VALID,
  input  logic [XLEN-1:0] RETIRE_NPC,
  input  logic            EXT_IRQ,
  input  logic            SW_IRQ,
  input  logic            TIMER_IRQ,
  input  logic            GLOBAL_IE,
  input  logic [2:0]      IRQ_EN,
  input  logic            DE_CS,
  output logic            CS,
  output logic [XLEN-1:0] CAUSE,
  output logic [XLEN-1:0] NPC,
  output logic            FLUSH,
  output logic            STALL,
  output logic            TRAP_ERR
);

  localparam int CNT_MAX = (FLUSH_CYCLES > ACK_TIMEOUT) ? FLUSH_CYCLES : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, FIRE, WAIT_ACK} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]   npc_q, npc_d;
  logic              cs_q, cs_d;
  logic              flush_q, flush_d;
  logic              stall_q, stall_d;
  logic              err_q, err_d;

  logic [2:0]        irq_pend;
  logic [4:0]        irq_code;

  assign irq_pend = {EXT_IRQ, SW_IRQ, TIMER_IRQ} & IRQ_EN;

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the if/case leaves it unassigned and infers a latch.
  always_comb begin
    irq_code = 5'd7;
    if (irq_pend[2])      irq_code = 5'd11;
    else if (irq_pend[1]) irq_code = 5'd3;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    npc_d   = npc_q;
    cs_d    = 1'b0;
    flush_d = flush_q;
    stall_d = stall_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (EXC_VALID) begin
          cause_d      = '0;
          cause_d[4:0] = EXC_CODE;
          npc_d        = EXC_PC;
          state_d      = DRAIN;
          flush_d      = 1'b1;
          stall_d      = 1'b1;
          cnt_d        = '0;
        end else if (GLOBAL_IE && RETIRE_VALID && (|irq_pend)) begin
          cause_d            = '0;
          cause_d[XLEN-1]    = 1'b1;
          cause_d[4:0]       = irq_code;
          npc_d              = RETIRE_NPC;
          state_d            = DRAIN;
          flush_d            = 1'b1;
          stall_d            = 1'b1;
          cnt_d              = '0;
        end
      end

      DRAIN: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = FIRE;
          flush_d = 1'b0;
          cs_d    = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      FIRE: begin
        state_d = WAIT_ACK;
        cnt_d   = '0;
      end

      WAIT_ACK: begin
        // An ack wins over a timeout landing on the same cycle.
        if (DE_CS) begin
          state_d = IDLE;
          stall_d = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == ACK_LAST) begin
          state_d = IDLE;
          stall_d = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cause_q <= '0;
      npc_q   <= '0;
      cs_q    <= 1'b0;
      flush_q <= 1'b0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      npc_q   <= npc_d;
      cs_q    <= cs_d;
      flush_q <= flush_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign CS       = cs_q;
  assign CAUSE    = cause_q;
  assign NPC      = npc_q;
  assign FLUSH    = flush_q;
  assign STALL    = stall_q;
  assign TRAP_ERR = err_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus pushes the expected CAUSE/NPC of each
// trap; a monitor pops and compares on every CS strobe.
module tb_trap_ctrl;

  localparam int XLEN = 64;

  logic            CLK;
  logic            RESET;
  logic            EXC_VALID;
  logic [4:0]      EXC_CODE;
  logic [XLEN-1:0] EXC_PC;
  logic            RETIRE_VALID;
  logic [XLEN-1:0] RETIRE_NPC;
  logic            EXT_IRQ, SW_IRQ, TIMER_IRQ;
  logic            GLOBAL_IE;
  logic [2:0]      IRQ_EN;
  logic            DE_CS;
  logic            CS;
  logic [XLEN-1:0] CAUSE, NPC;
  logic            FLUSH, STALL, TRAP_ERR;

  trap_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(2), .ACK_TIMEOUT(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .EXC_VALID(EXC_VALID), .EXC_CODE(EXC_CODE), .EXC_PC(EXC_PC),
    .RETIRE_VALID(RETIRE_VALID), .RETIRE_NPC(RETIRE_NPC),
    .EXT_IRQ(EXT_IRQ), .SW_IRQ(SW_IRQ), .TIMER_IRQ(TIMER_IRQ),
    .GLOBAL_IE(GLOBAL_IE), .IRQ_EN(IRQ_EN), .DE_CS(DE_CS),
    .CS(CS), .CAUSE(CAUSE), .NPC(NPC),
    .FLUSH(FLUSH), .STALL(STALL), .TRAP_ERR(TRAP_ERR)
  );

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] npc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  // Monitor: every CS strobe must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (!RESET && CS === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_cs", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_cause", CAUSE, e.cause);
        check("sb_npc", NPC, e.npc);
      end
    end
  end

  task automatic wait_cs(input string name);
    int n;
    n = 0;
    while (CS !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(name, {63'd0, CS}, 64'd1);
  endtask

  // Called in the FIRE cycle; acks in the first WAIT_ACK cycle.
  task automatic ack();
    tick();
    DE_CS = 1'b1;
    tick();
    DE_CS = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cs"}, {63'd0, CS}, 64'd0);
    check({tag, "_flush"}, {63'd0, FLUSH}, 64'd0);
    check({tag, "_stall"}, {63'd0, STALL}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; EXC_VALID = 1'b0; EXC_CODE = '0; EXC_PC = '0;
    RETIRE_VALID = 1'b0; RETIRE_NPC = '0;
    EXT_IRQ = 1'b0; SW_IRQ = 1'b0; TIMER_IRQ = 1'b0;
    GLOBAL_IE = 1'b0; IRQ_EN = 3'b000; DE_CS = 1'b0;
    tick(); tick();

    // Reset state
    check_idle_outputs("rst");
    check("rst_err", {63'd0, TRAP_ERR}, 64'd0);
    check("rst_cause", CAUSE, 64'd0);
    check("rst_npc", NPC, 64'd0);
    RESET = 1'b0;
    tick();

    // Exception with exact cycle timing: cycle 0 stimulus, CS in cycle 3
    EXC_VALID = 1'b1; EXC_CODE = 5'd2; EXC_PC = 64'h1000;
    sb.push_back('{cause: 64'h2, npc: 64'h1000});
    tick();                                   // cycle 1
    EXC_VALID = 1'b0;
    check("c1_flush", {63'd0, FLUSH}, 64'd1);
    check("c1_stall", {63'd0, STALL}, 64'd1);
    check("c1_cs", {63'd0, CS}, 64'd0);
    check("c1_cause", CAUSE, 64'h2);
    tick();                                   // cycle 2
    check("c2_flush", {63'd0, FLUSH}, 64'd1);
    check("c2_cs", {63'd0, CS}, 64'd0);
    tick();                                   // cycle 3
    check("c3_cs", {63'd0, CS}, 64'd1);
    check("c3_flush", {63'd0, FLUSH}, 64'd0);
    tick();                                   // cycle 4
    check("c4_cs", {63'd0, CS}, 64'd0);
    check("c4_stall", {63'd0, STALL}, 64'd1);
    tick();                                   // cycle 5
    DE_CS = 1'b1;
    tick();                                   // cycle 6
    DE_CS = 1'b0;
    check("c6_stall", {63'd0, STALL}, 64'd0);
    check("c6_cause_hold", CAUSE, 64'h2);
    check("c6_npc_hold", NPC, 64'h1000);

    // Timer interrupt gated by RETIRE_VALID and GLOBAL_IE
    GLOBAL_IE = 1'b1; IRQ_EN = 3'b111; TIMER_IRQ = 1'b1;
    RETIRE_VALID = 1'b0; RETIRE_NPC = 64'h2004;
    tick(); tick();
    check("no_retire_stall", {63'd0, STALL}, 64'd0);
    GLOBAL_IE = 1'b0; RETIRE_VALID = 1'b1;
    tick(); tick();
    check("no_gie_stall", {63'd0, STALL}, 64'd0);
    GLOBAL_IE = 1'b1;
    sb.push_back('{cause: 64'h8000_0000_0000_0007, npc: 64'h2004});
    tick();
    RETIRE_VALID = 1'b0; TIMER_IRQ = 1'b0;
    check("timer_stall", {63'd0, STALL}, 64'd1);
    wait_cs("timer_cs");
    ack();

    // All three interrupts: EXT wins
    EXT_IRQ = 1'b1; SW_IRQ = 1'b1; TIMER_IRQ = 1'b1;
    RETIRE_VALID = 1'b1; RETIRE_NPC = 64'h3000;
    sb.push_back('{cause: 64'h8000_0000_0000_000B, npc: 64'h3000});
    tick();
    EXT_IRQ = 1'b0; SW_IRQ = 1'b0; TIMER_IRQ = 1'b0; RETIRE_VALID = 1'b0;
    wait_cs("ext_cs");
    ack();

    // SW over TIMER when EXT disabled by IRQ_EN
    EXT_IRQ = 1'b1; SW_IRQ = 1'b1; TIMER_IRQ = 1'b1; IRQ_EN = 3'b011;
    RETIRE_VALID = 1'b1; RETIRE_NPC = 64'h3800;
    sb.push_back('{cause: 64'h8000_0000_0000_0003, npc: 64'h3800});
    tick();
    EXT_IRQ = 1'b0; SW_IRQ = 1'b0; TIMER_IRQ = 1'b0; RETIRE_VALID = 1'b0;
    IRQ_EN = 3'b111;
    wait_cs("sw_cs");
    ack();

    // Exception beats pending interrupts; interrupt follows after return
    EXT_IRQ = 1'b1; SW_IRQ = 1'b1; TIMER_IRQ = 1'b1;
    RETIRE_VALID = 1'b1; RETIRE_NPC = 64'h4100;
    EXC_VALID = 1'b1; EXC_CODE = 5'd8; EXC_PC = 64'h4000;
    sb.push_back('{cause: 64'h8, npc: 64'h4000});
    sb.push_back('{cause: 64'h8000_0000_0000_000B, npc: 64'h4100});
    tick();
    EXC_VALID = 1'b0;
    wait_cs("exc_first_cs");
    ack();
    tick();
    EXT_IRQ = 1'b0; SW_IRQ = 1'b0; TIMER_IRQ = 1'b0; RETIRE_VALID = 1'b0;
    check("irq_after_exc_stall", {63'd0, STALL}, 64'd1);
    wait_cs("irq_second_cs");
    ack();

    // Ack timeout: WAIT_ACK lasts 16 cycles, then TRAP_ERR and IDLE
    EXC_VALID = 1'b1; EXC_CODE = 5'd5; EXC_PC = 64'h5000;
    sb.push_back('{cause: 64'h5, npc: 64'h5000});
    tick();
    EXC_VALID = 1'b0;
    wait_cs("to_cs");
    repeat (16) tick();
    check("to_err_before", {63'd0, TRAP_ERR}, 64'd0);
    check("to_stall_before", {63'd0, STALL}, 64'd1);
    tick();
    check("to_err", {63'd0, TRAP_ERR}, 64'd1);
    check("to_stall", {63'd0, STALL}, 64'd0);
    EXC_VALID = 1'b1; EXC_CODE = 5'd3; EXC_PC = 64'h6000;
    sb.push_back('{cause: 64'h3, npc: 64'h6000});
    tick();
    EXC_VALID = 1'b0;
    wait_cs("after_to_cs");
    ack();
    check("err_sticky", {63'd0, TRAP_ERR}, 64'd1);

    // Reset during DRAIN discards the trap
    EXC_VALID = 1'b1; EXC_CODE = 5'd4; EXC_PC = 64'h7000;
    tick();
    EXC_VALID = 1'b0;
    check("pre_rst_flush", {63'd0, FLUSH}, 64'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check_idle_outputs("drain_rst");
    check("drain_rst_err", {63'd0, TRAP_ERR}, 64'd0);
    check("drain_rst_cause", CAUSE, 64'd0);
    check("drain_rst_npc", NPC, 64'd0);
    repeat (10) tick();
    check("drain_rst_later_stall", {63'd0, STALL}, 64'd0);

    // Stray DE_CS in IDLE
    DE_CS = 1'b1;
    tick();
    DE_CS = 1'b0;
    check_idle_outputs("stray_ack");
    repeat (3) tick();
    check_idle_outputs("stray_ack_later");
    check("stray_ack_cause", CAUSE, 64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
